// File: rtl/sm_key_step.sv
// Debounced push-button conditioner: clean key level, one-cycle step pulses on press and
// optional auto-repeat while held, plus a wrap-around pulse count for LED display.
module sm_key_step #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic       clkIn,
    input  logic       rst_n,
    input  logic       keyIn_n,
    input  logic       repeatEn,
    output logic       keyLevel,
    output logic       keyPulse,
    output logic [7:0] pressCount
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REPEAT,
        RELEASE_DB
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sync_s1;
    logic             sync_s2;
    logic             pressed;

    // Synchronizer flops idle at 1 so a reset never looks like a press.
    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            sync_s1 <= 1'b1;
            sync_s2 <= 1'b1;
        end else begin
            sync_s1 <= keyIn_n;
            sync_s2 <= sync_s1;
        end
    end

    assign pressed = ~sync_s2;

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            keyLevel   <= 1'b0;
            keyPulse   <= 1'b0;
            pressCount <= 8'd0;
        end else begin
            keyPulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= PRESS_DB;
                        cnt   <= '0;
                    end
                end

                PRESS_DB: begin
                    if (!pressed) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state      <= HELD;
                        cnt        <= '0;
                        keyLevel   <= 1'b1;
                        keyPulse   <= 1'b1;
                        pressCount <= pressCount + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                HELD: begin
                    if (!pressed) begin
                        state <= RELEASE_DB;
                        cnt   <= '0;
                    end else if (!repeatEn) begin
                        cnt <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state      <= REPEAT;
                        cnt        <= '0;
                        keyPulse   <= 1'b1;
                        pressCount <= pressCount + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                REPEAT: begin
                    if (!pressed) begin
                        state <= RELEASE_DB;
                        cnt   <= '0;
                    end else if (!repeatEn) begin
                        cnt <= '0;
                    end else if (cnt == REPEAT_LAST) begin
                        cnt        <= '0;
                        keyPulse   <= 1'b1;
                        pressCount <= pressCount + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RELEASE_DB: begin
                    // A bounce back to pressed keeps the key down but restarts the hold timer.
                    if (pressed) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        keyLevel <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_key_step.sv
// Randomized and directed bench for sm_key_step against a run-length based key model.
module tb_sm_key_step;

    localparam int DB  = 4;
    localparam int HC  = 20;
    localparam int RC  = 8;

    logic       clkIn;
    logic       rst_n;
    logic       keyIn_n;
    logic       repeatEn;
    logic       keyLevel;
    logic       keyPulse;
    logic [7:0] pressCount;

    int total;
    int bad;

    // Model state: two synchronizer stages, accepted level, length of the current run of
    // samples disagreeing with the level, time since the last hold anchor, pulse count.
    int mS1;
    int mS2;
    int mLevel;
    int mRun;
    int mTime;
    int mFirst;
    int mPulse;
    int mCount;
    int prevPulse;

    sm_key_step #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HC),
        .REPEAT_CYCLES  (RC),
        .CNT_W          (8)
    ) dut (
        .clkIn     (clkIn),
        .rst_n     (rst_n),
        .keyIn_n   (keyIn_n),
        .repeatEn  (repeatEn),
        .keyLevel  (keyLevel),
        .keyPulse  (keyPulse),
        .pressCount(pressCount)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mS1    = 1;
        mS2    = 1;
        mLevel = 0;
        mRun   = 0;
        mTime  = 0;
        mFirst = 1;
        mPulse = 0;
        mCount = 0;
        prevPulse = 0;
    endtask

    // One clock edge of the key model, driven by the sample the conditioner sees at that edge.
    task automatic modelStep(input int raw, input int rep);
        int p;
        p = (mS2 == 0) ? 1 : 0;
        mS2 = mS1;
        mS1 = raw;
        mPulse = 0;
        if (mLevel == 0) begin
            mRun = p ? mRun + 1 : 0;
            if (mRun == DB + 1) begin
                mLevel = 1;
                mRun   = 0;
                mPulse = 1;
                mTime  = 0;
                mFirst = 1;
            end
        end else if (p == 0) begin
            mRun++;
            if (mRun == DB + 1) begin
                mLevel = 0;
                mRun   = 0;
            end
        end else if (mRun > 0) begin
            mRun   = 0;
            mTime  = 0;
            mFirst = 1;
        end else if (rep == 0) begin
            mTime = 0;
        end else begin
            mTime++;
            if (mTime == (mFirst ? HC : RC)) begin
                mPulse = 1;
                mTime  = 0;
                mFirst = 0;
            end
        end
        mCount = (mCount + mPulse) % 256;
    endtask

    task automatic applyStimulus(input int raw, input int rep);
        keyIn_n  = raw[0];
        repeatEn = rep[0];
        @(posedge clkIn);
        modelStep(raw, rep);
        #1;
        checkOutput("keyLevel", int'(keyLevel), mLevel);
        checkOutput("keyPulse", int'(keyPulse), mPulse);
        checkOutput("pressCount", int'(pressCount), mCount);
        checkOutput("no_back_to_back", int'(keyPulse) & prevPulse, 0);
        prevPulse = int'(keyPulse);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_keyLevel", int'(keyLevel), 0);
        checkOutput("rst_keyPulse", int'(keyPulse), 0);
        checkOutput("rst_pressCount", int'(pressCount), 0);
        @(negedge clkIn);
        @(negedge clkIn);
        rst_n = 1'b1;
    endtask

    initial begin
        int startCnt;
        int raw;
        int rep;
        int len;
        total    = 0;
        bad      = 0;
        keyIn_n  = 1'b1;
        repeatEn = 1'b0;
        rst_n    = 1'b1;
        modelReset();
        #2;
        doReset();

        // 1: short glitch is rejected
        for (int i = 1; i <= 3; i++) applyStimulus(0, 0);
        for (int i = 1; i <= 10; i++) applyStimulus(1, 0);
        checkOutput("t1_count", int'(pressCount), 0);

        // 2: single press, no repeat
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(0, 0);
            checkOutput("t2_pulse_edge", int'(keyPulse), (i == 7) ? 1 : 0);
            checkOutput("t2_level_edge", int'(keyLevel), (i >= 7) ? 1 : 0);
        end
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1, 0);
            checkOutput("t2_release_edge", int'(keyLevel), (i < 7) ? 1 : 0);
        end
        checkOutput("t2_count", int'(pressCount), 1);

        // 3: auto-repeat schedule
        startCnt = mCount;
        for (int i = 1; i <= 62; i++) begin
            applyStimulus(0, 1);
            checkOutput("t3_pulse_edge", int'(keyPulse),
                        (i == 7 || i == 27 || i == 35 || i == 43 || i == 51 || i == 59) ? 1 : 0);
        end
        for (int i = 1; i <= 10; i++) applyStimulus(1, 1);
        checkOutput("t3_count", int'(pressCount), (startCnt + 6) % 256);

        // 4: release bounce while held
        for (int i = 1; i <= 10; i++) applyStimulus(0, 0);
        startCnt = mCount;
        for (int i = 1; i <= 2; i++) applyStimulus(1, 0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(0, 0);
            checkOutput("t4_level", int'(keyLevel), 1);
        end
        checkOutput("t4_count", int'(pressCount), startCnt);

        // 5: asynchronous reset mid-hold, key still pressed afterwards
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("t5_async_level", int'(keyLevel), 0);
        checkOutput("t5_async_count", int'(pressCount), 0);
        @(negedge clkIn);
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(0, 0);
            checkOutput("t5_pulse_edge", int'(keyPulse), (i == 7) ? 1 : 0);
        end
        for (int i = 1; i <= 10; i++) applyStimulus(1, 0);

        // Randomized bouncy presses with repeatEn toggling
        rep = 0;
        for (int seg = 0; seg < 60; seg++) begin
            raw = int'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70)) : int'($urandom_range(1, 8));
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 15) == 0) rep = 1 - rep;
                applyStimulus(raw, rep);
            end
        end
        for (int i = 1; i <= 10; i++) applyStimulus(1, 0);

        // 6: pressCount wraps after 256 presses
        doReset();
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < 8; i++) applyStimulus(0, 0);
            for (int i = 0; i < 9; i++) applyStimulus(1, 0);
        end
        checkOutput("t6_wrap", int'(pressCount), 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0);
        checkOutput("t6_after_wrap", int'(pressCount), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
